// File: rtl/credit_bp_rx.sv
// credit_bp_rx: receiver half of a credit-based backpressure link.
// Each VC has its own FIFO holding DEPTH-1 flits. A round-robin selector
// presents one non-empty VC head per cycle to the switch. Every accepted pop
// returns one registered credit pulse upstream on the following cycle.
// Optional feature macro: CREDIT_BP_RX_OVF_STATUS_EN adds the sticky per-VC
// overflow flag output o_ovf.
module credit_bp_rx #(
  parameter int VC_W  = 2,
  parameter int D_W   = 8,
  parameter int X_W   = 4,
  parameter int Y_W   = 4,
  parameter int A_W   = X_W + Y_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [D_W-1:0]   from_tx_data,
  input  logic [A_W-1:0]   from_tx_addr,
  input  logic [VC_W-1:0]  from_tx_vc_target,
  output logic [VC_W-1:0]  from_tx_vc_credit_gnt,
  output logic [VC_W-1:0]  o_v,
  output logic [X_W-1:0]   o_x,
  output logic [Y_W-1:0]   o_y,
  output logic [D_W-1:0]   o_d,
`ifdef CREDIT_BP_RX_OVF_STATUS_EN
  output logic [VC_W-1:0]  o_ovf,
`endif
  input  logic [VC_W-1:0]  i_b
);

  localparam int E_W     = A_W + D_W;
  localparam int ENTRIES = DEPTH - 1;
  localparam int PTR_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CNT_W   = $clog2(DEPTH);
  localparam int SEL_W   = (VC_W > 1) ? $clog2(VC_W) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(ENTRIES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ENTRIES);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(VC_W - 1);

  logic [SEL_W-1:0]           rr_ptr_reg;
  logic [VC_W-1:0]            gnt_reg;
  logic [E_W-1:0]             last_reg;
  logic [VC_W-1:0]            non_empty;
  logic [VC_W-1:0][E_W-1:0]   head_all;
  logic [SEL_W-1:0]           sel;
  logic [SEL_W-1:0]           idx;
  logic                       any_valid;
  logic [VC_W-1:0]            sel_vec;
  logic [VC_W-1:0]            pop_vec;
  logic [E_W-1:0]             head_ent;
  logic [E_W-1:0]             out_ent;
  logic [SEL_W-1:0]           rr_ptr_next;

  // Round-robin search: first non-empty VC at or after the rr pointer.
  always_comb begin
    sel       = '0;
    idx       = '0;
    any_valid = 1'b0;
    for (int k = 0; k < VC_W; k++) begin
      idx = SEL_W'((int'(rr_ptr_reg) + k) % VC_W);
      if (!any_valid && non_empty[idx]) begin
        any_valid = 1'b1;
        sel       = idx;
      end
    end
  end

  assign sel_vec     = VC_W'(1) << sel;
  assign pop_vec     = (any_valid && !i_b[sel]) ? sel_vec : '0;
  assign head_ent    = head_all[sel];
  // With nothing presented the data outputs simply keep the last shown flit.
  assign out_ent     = any_valid ? head_ent : last_reg;
  assign rr_ptr_next = (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);

  assign o_v                   = any_valid ? sel_vec : '0;
  assign o_x                   = out_ent[E_W-1 -: X_W];
  assign o_y                   = out_ent[D_W +: Y_W];
  assign o_d                   = out_ent[D_W-1:0];
  assign from_tx_vc_credit_gnt = gnt_reg;

  // Arbiter pointer, one-cycle-late credit pulse and held output flit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
      gnt_reg    <= '0;
      last_reg   <= '0;
    end else begin
      gnt_reg <= pop_vec;
      if (any_valid) begin
        rr_ptr_reg <= rr_ptr_next;
        last_reg   <= head_ent;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < VC_W; gi++) begin : g_vc
      logic [E_W-1:0]   mem_reg [ENTRIES];
      logic [PTR_W-1:0] wr_ptr_reg;
      logic [PTR_W-1:0] rd_ptr_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             push;
      logic             pop_here;
      logic             full;
      logic             do_write;

      assign push          = from_tx_vc_target[gi];
      assign pop_here      = pop_vec[gi];
      assign full          = (cnt_reg == CNT_FULL);
      // A full FIFO still accepts a write when the same edge pops it.
      assign do_write      = push && (!full || pop_here);
      assign non_empty[gi] = (cnt_reg != '0);
      assign head_all[gi]  = mem_reg[rd_ptr_reg];

      // Flit storage; contents need no reset because count gates visibility.
      always_ff @(posedge clk) begin
        if (do_write) begin
          mem_reg[wr_ptr_reg] <= {from_tx_addr, from_tx_data};
        end
      end

      // Pointer and occupancy bookkeeping; overflow writes leave all unchanged.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          cnt_reg    <= '0;
        end else begin
          if (do_write) begin
            wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
          end
          if (pop_here) begin
            rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
          end
          if (do_write && !pop_here) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end else if (!do_write && pop_here) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
      end

`ifdef CREDIT_BP_RX_OVF_STATUS_EN
      logic ovf_reg;
      // Sticky flag recording any dropped write on this VC.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_reg <= 1'b0;
        end else if (push && full && !pop_here) begin
          ovf_reg <= 1'b1;
        end
      end
      assign o_ovf[gi] = ovf_reg;
`endif

`ifdef SIMULATION
      // Flag writes that a well-behaved transmitter should never issue.
      always @(posedge clk) begin
        if (rst_n) begin
          assert (!(push && full && !pop_here))
            else $warning("credit_bp_rx: overflow write dropped on VC %0d", gi);
        end
      end
`endif
    end
  endgenerate

`ifdef SIMULATION
  // More than one target VC in a cycle is a link protocol violation.
  always @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(from_tx_vc_target))
        else $error("credit_bp_rx: vc_target not onehot0");
    end
  end
`endif

endmodule

// File: tb/tb_credit_bp_rx.sv
// Bench for credit_bp_rx: per-VC queue model plus directed scenarios.
`timescale 1ns/1ps
module tb_credit_bp_rx;
  localparam int VC_W  = 2;
  localparam int D_W   = 8;
  localparam int X_W   = 4;
  localparam int Y_W   = 4;
  localparam int A_W   = X_W + Y_W;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [D_W-1:0]   data = '0;
  logic [A_W-1:0]   addr = '0;
  logic [VC_W-1:0]  vc_target = '0;
  logic [VC_W-1:0]  gnt;
  logic [VC_W-1:0]  o_v;
  logic [X_W-1:0]   o_x;
  logic [Y_W-1:0]   o_y;
  logic [D_W-1:0]   o_d;
  logic [VC_W-1:0]  i_b = '0;
`ifdef CREDIT_BP_RX_OVF_STATUS_EN
  logic [VC_W-1:0]  o_ovf;
`endif

  int checks = 0;
  int errors = 0;

  credit_bp_rx #(
    .VC_W(VC_W), .D_W(D_W), .X_W(X_W), .Y_W(Y_W), .A_W(A_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .from_tx_data(data),
    .from_tx_addr(addr),
    .from_tx_vc_target(vc_target),
    .from_tx_vc_credit_gnt(gnt),
    .o_v(o_v),
    .o_x(o_x),
    .o_y(o_y),
    .o_d(o_d),
`ifdef CREDIT_BP_RX_OVF_STATUS_EN
    .o_ovf(o_ovf),
`endif
    .i_b(i_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: one queue per VC ----------------
  logic [15:0] mq0[$];
  logic [15:0] mq1[$];
  int          m_rr = 0;
  logic [1:0]  m_gnt = '0;
  logic [15:0] m_last = '0;
  logic [1:0]  m_ovf = '0;

  function automatic int qsize(input int v);
    return (v == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [15:0] head_of(input int v);
    return (v == 0) ? mq0[0] : mq1[0];
  endfunction

  function automatic int model_sel();
    for (int k = 0; k < VC_W; k++) begin
      if (qsize((m_rr + k) % VC_W) > 0) return (m_rr + k) % VC_W;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_upd
    int   s;
    logic popv;
    if (!rst_n) begin
      mq0.delete();
      mq1.delete();
      m_rr   = 0;
      m_gnt  = '0;
      m_last = '0;
      m_ovf  = '0;
    end else begin
      s    = model_sel();
      popv = (s >= 0) && !i_b[s];
      if (s >= 0) m_last = head_of(s);
      m_gnt = popv ? (2'b01 << s) : 2'b00;
      if (popv) begin
        if (s == 0) void'(mq0.pop_front());
        else        void'(mq1.pop_front());
      end
      if (vc_target[0]) begin
        if (mq0.size() < DEPTH - 1) mq0.push_back({addr, data});
        else m_ovf[0] = 1'b1;
      end
      if (vc_target[1]) begin
        if (mq1.size() < DEPTH - 1) mq1.push_back({addr, data});
        else m_ovf[1] = 1'b1;
      end
      if (s >= 0) m_rr = (s + 1) % VC_W;
    end
  end

  // Compare DUT against model on every falling edge.
  always @(negedge clk) begin : compare
    int          s;
    logic [1:0]  exp_v;
    logic [15:0] exp_e;
    s     = model_sel();
    exp_v = (s >= 0) ? (2'b01 << s) : 2'b00;
    exp_e = (s >= 0) ? head_of(s) : m_last;
    chk("model_o_v", 32'(o_v), 32'(exp_v));
    chk("model_flit", 32'({o_x, o_y, o_d}), 32'(exp_e));
    chk("model_gnt", 32'(gnt), 32'(m_gnt));
`ifdef CREDIT_BP_RX_OVF_STATUS_EN
    chk("model_ovf", 32'(o_ovf), 32'(m_ovf));
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v, input logic [15:0] ent);
    vc_target = 2'b01 << v;
    addr      = ent[15:8];
    data      = ent[7:0];
    step();
    vc_target = '0;
  endtask

  task automatic expect_at_neg(input string nm, input logic [1:0] v,
                               input logic [7:0] d, input logic [1:0] g);
    @(negedge clk);
    chk({nm, "_v"}, 32'(o_v), 32'(v));
    if (v != 2'b00) chk({nm, "_d"}, 32'(o_d), 32'(d));
    chk({nm, "_gnt"}, 32'(gnt), 32'(g));
    $display("txn %s: o_v=%b o_d=%h gnt=%b", nm, o_v, o_d, gnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    #1;
    chk("reset_o_v", 32'(o_v), 32'h0);
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_flit", 32'({o_x, o_y, o_d}), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // 1: single flit on VC0, immediate accept, credit next cycle
    i_b = 2'b00;
    push(0, 16'h12AB);
    @(negedge clk);
    chk("t1_o_v", 32'(o_v), 32'h1);
    chk("t1_o_d", 32'(o_d), 32'hAB);
    chk("t1_o_x", 32'(o_x), 32'h1);
    chk("t1_o_y", 32'(o_y), 32'h2);
    chk("t1_gnt0", 32'(gnt), 32'h0);
    expect_at_neg("t1_credit", 2'b00, 8'h00, 2'b01);
    expect_at_neg("t1_idle", 2'b00, 8'h00, 2'b00);
    step();

    // 2: backpressured VC1 fills, then drains in order
    i_b = 2'b11;
    push(1, 16'h5511);
    push(1, 16'h5522);
    push(1, 16'h5533);
    expect_at_neg("t2_hold", 2'b10, 8'h11, 2'b00);
    step();
    i_b = 2'b00;
    expect_at_neg("t2_pop0", 2'b10, 8'h11, 2'b00);
    expect_at_neg("t2_pop1", 2'b10, 8'h22, 2'b10);
    expect_at_neg("t2_pop2", 2'b10, 8'h33, 2'b10);
    expect_at_neg("t2_done", 2'b00, 8'h00, 2'b10);
    step();

    // 3: both VCs loaded, round-robin alternation
    i_b = 2'b11;
    push(0, 16'h30A0);
    push(0, 16'h31A1);
    push(1, 16'h40B0);
    push(1, 16'h41B1);
    i_b = 2'b00;
    expect_at_neg("t3_a0", 2'b01, 8'hA0, 2'b00);
    expect_at_neg("t3_b0", 2'b10, 8'hB0, 2'b01);
    expect_at_neg("t3_a1", 2'b01, 8'hA1, 2'b10);
    expect_at_neg("t3_b1", 2'b10, 8'hB1, 2'b01);
    expect_at_neg("t3_done", 2'b00, 8'h00, 2'b10);
    step();

    // 4: VC0 full, push and pop on the same edge
    i_b = 2'b11;
    push(0, 16'h60C0);
    push(0, 16'h61C1);
    push(0, 16'h62C2);
    i_b = 2'b00;
    push(0, 16'h63C3);
    expect_at_neg("t4_c1", 2'b01, 8'hC1, 2'b01);
    expect_at_neg("t4_c2", 2'b01, 8'hC2, 2'b01);
    expect_at_neg("t4_c3", 2'b01, 8'hC3, 2'b01);
    expect_at_neg("t4_done", 2'b00, 8'h00, 2'b01);
`ifdef CREDIT_BP_RX_OVF_STATUS_EN
    chk("t4_no_ovf", 32'(o_ovf), 32'h0);
`endif
    step();

    // 5: VC0 full under backpressure, extra write dropped
    i_b = 2'b11;
    push(0, 16'h70D0);
    push(0, 16'h71D1);
    push(0, 16'h72D2);
    push(0, 16'h73D3);
    i_b = 2'b00;
    expect_at_neg("t5_d0", 2'b01, 8'hD0, 2'b00);
`ifdef CREDIT_BP_RX_OVF_STATUS_EN
    chk("t5_ovf_set", 32'(o_ovf), 32'h1);
`endif
    expect_at_neg("t5_d1", 2'b01, 8'hD1, 2'b01);
    expect_at_neg("t5_d2", 2'b01, 8'hD2, 2'b01);
    expect_at_neg("t5_done", 2'b00, 8'h00, 2'b01);
`ifdef CREDIT_BP_RX_OVF_STATUS_EN
    chk("t5_ovf_sticky", 32'(o_ovf), 32'h1);
`endif
    step();

    // 6: asynchronous reset with flits queued and a credit in flight
    i_b = 2'b11;
    push(1, 16'h80E0);
    push(1, 16'h81E1);
    push(1, 16'h82E2);
    i_b = 2'b00;
    step();
    chk("t6_pre_gnt", 32'(gnt), 32'h2);
    chk("t6_pre_o_v", 32'(o_v), 32'h2);
    chk("t6_pre_d", 32'(o_d), 32'hE1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_o_v", 32'(o_v), 32'h0);
    chk("t6_rst_gnt", 32'(gnt), 32'h0);
    chk("t6_rst_flit", 32'({o_x, o_y, o_d}), 32'h0);
`ifdef CREDIT_BP_RX_OVF_STATUS_EN
    chk("t6_rst_ovf", 32'(o_ovf), 32'h0);
`endif
    $display("txn t6_reset: o_v=%b gnt=%b", o_v, gnt);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    expect_at_neg("t6_after0", 2'b00, 8'h00, 2'b00);
    expect_at_neg("t6_after1", 2'b00, 8'h00, 2'b00);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
